// File: rtl/alu_control_unit.sv
// RV32I ALU control decoder: maps ALUOp and {inst[30], funct3} to a registered
// ALU operation select and an illegal-encoding flag.
module alu_control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ALUOp,
  input  logic [3:0] Inst,
  output logic [3:0] ALUSel,
  output logic       illegal
);

  localparam int unsigned SEL_W = 4;

  localparam logic [SEL_W-1:0] SEL_ADD  = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_SUB  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_OR   = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_AND  = 4'b0101;
  localparam logic [SEL_W-1:0] SEL_XOR  = 4'b0111;
  localparam logic [SEL_W-1:0] SEL_SRL  = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_SLL  = 4'b1001;
  localparam logic [SEL_W-1:0] SEL_SRA  = 4'b1010;
  localparam logic [SEL_W-1:0] SEL_SLT  = 4'b1101;
  localparam logic [SEL_W-1:0] SEL_SLTU = 4'b1111;

  localparam logic [1:0] OP_MEM    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_RTYPE  = 2'b10;
  localparam logic [1:0] OP_ITYPE  = 2'b11;

  logic             alt;
  logic [2:0]       funct3;
  logic [SEL_W-1:0] sel_c;
  logic             illegal_c;

  assign alt    = Inst[3];
  assign funct3 = Inst[2:0];

  // Combinational decode; inst[30] selects SUB/SRA in R-type, only SRA in I-type
  always_comb begin
    sel_c     = SEL_ADD;
    illegal_c = 1'b0;
    case (ALUOp)
      OP_MEM:    sel_c = SEL_ADD;
      OP_BRANCH: sel_c = SEL_SUB;
      OP_RTYPE: begin
        case (funct3)
          3'b000:  sel_c = alt ? SEL_SUB : SEL_ADD;
          3'b001:  sel_c = SEL_SLL;
          3'b010:  sel_c = SEL_SLT;
          3'b011:  sel_c = SEL_SLTU;
          3'b100:  sel_c = SEL_XOR;
          3'b101:  sel_c = alt ? SEL_SRA : SEL_SRL;
          3'b110:  sel_c = SEL_OR;
          3'b111:  sel_c = SEL_AND;
          default: sel_c = SEL_ADD;
        endcase
        illegal_c = alt && (funct3 != 3'b000) && (funct3 != 3'b101);
      end
      OP_ITYPE: begin
        case (funct3)
          3'b000:  sel_c = SEL_ADD;
          3'b001:  sel_c = SEL_SLL;
          3'b010:  sel_c = SEL_SLT;
          3'b011:  sel_c = SEL_SLTU;
          3'b100:  sel_c = SEL_XOR;
          3'b101:  sel_c = alt ? SEL_SRA : SEL_SRL;
          3'b110:  sel_c = SEL_OR;
          3'b111:  sel_c = SEL_AND;
          default: sel_c = SEL_ADD;
        endcase
        // Elsewhere inst[30] is immediate data; only a shift-left shamt must keep it clear
        illegal_c = alt && (funct3 == 3'b001);
      end
      default: begin
        sel_c     = SEL_ADD;
        illegal_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUSel  <= SEL_ADD;
      illegal <= 1'b0;
    end else begin
      ALUSel  <= sel_c;
      illegal <= illegal_c;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Bench for alu_control_unit: table-driven reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ALUOp;
  logic [3:0] Inst;
  logic [3:0] ALUSel;
  logic       illegal;

  int vectors    = 0;
  int miscompares = 0;
  bit model_on   = 1'b0;

  alu_control_unit dut (
    .clk     (clk),
    .rst     (rst),
    .ALUOp   (ALUOp),
    .Inst    (Inst),
    .ALUSel  (ALUSel),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  // Reference: operation named by funct3, with inst[30] picking the alternate form
  function automatic logic [4:0] model(input logic [1:0] op, input logic [3:0] inst);
    logic [3:0] base [8];
    logic [2:0] f3;
    logic       a;
    logic [3:0] sel;
    logic       ill;
    base = '{4'b0000, 4'b1001, 4'b1101, 4'b1111, 4'b0111, 4'b1000, 4'b0100, 4'b0101};
    f3  = inst[2:0];
    a   = inst[3];
    sel = 4'b0000;
    ill = 1'b0;
    if (op == 2'd0) sel = 4'b0000;
    else if (op == 2'd1) sel = 4'b0001;
    else begin
      sel = base[f3];
      if (a && f3 == 3'd5) sel = 4'b1010;
      if (a && f3 == 3'd0 && op == 2'd2) sel = 4'b0001;
      if (op == 2'd2) ill = a && !(f3 == 3'd0 || f3 == 3'd5);
      else            ill = a && (f3 == 3'd1);
    end
    return {sel, ill};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got sel=%b ill=%b, expected sel=%b ill=%b @%0t",
               name, act[4:1], act[0], exp[4:1], exp[0], $time);
    end
  endtask

  // Model-side capture of the previous edge's inputs
  logic [4:0] exp_q;
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q <= 5'b0;
    else     exp_q <= model(ALUOp, Inst);
  end

  always @(negedge clk) begin
    if (model_on) check("model", {ALUSel, illegal}, rst ? 5'b0 : exp_q);
  end

  task automatic step(input string name, input logic [1:0] op, input logic [3:0] inst,
                      input logic [3:0] esel, input logic eill);
    @(negedge clk);
    ALUOp = op;
    Inst  = inst;
    @(posedge clk);
    #1;
    check(name, {ALUSel, illegal}, {esel, eill});
  endtask

  logic [3:0] r_exp [8];
  logic [3:0] i_exp [8];

  initial begin
    r_exp = '{4'b0000, 4'b1001, 4'b1101, 4'b1111, 4'b0111, 4'b1000, 4'b0100, 4'b0101};
    i_exp = '{4'b0000, 4'b1001, 4'b1101, 4'b1111, 4'b0111, 4'b1010, 4'b0100, 4'b0101};

    rst   = 1'b1;
    ALUOp = 2'b10;
    Inst  = 4'b1000;
    #1;
    check("reset_async", {ALUSel, illegal}, 5'b0000_0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {ALUSel, illegal}, 5'b0000_0);
    model_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", {ALUSel, illegal}, 5'b0001_0);

    step("mem_add",    2'b00, 4'b0000, 4'b0000, 1'b0);
    step("branch_sub", 2'b01, 4'b0000, 4'b0001, 1'b0);
    step("mem_ign",    2'b00, 4'b1111, 4'b0000, 1'b0);
    step("branch_ign", 2'b01, 4'b1011, 4'b0001, 1'b0);

    for (int i = 0; i < 8; i++)
      step($sformatf("r_f3_%0d", i), 2'b10, 4'(i), r_exp[i], 1'b0);
    step("r_sub", 2'b10, 4'b1000, 4'b0001, 1'b0);
    step("r_sra", 2'b10, 4'b1101, 4'b1010, 1'b0);
    step("r_ill_sll", 2'b10, 4'b1001, 4'b1001, 1'b1);
    step("r_ill_and", 2'b10, 4'b1111, 4'b0101, 1'b1);

    for (int i = 0; i < 8; i++)
      step($sformatf("i_f3_%0d", i), 2'b11, 4'(8 + i), i_exp[i], (i == 1));
    step("i_srl", 2'b11, 4'b0101, 4'b1000, 1'b0);
    step("i_sll_ok", 2'b11, 4'b0001, 4'b1001, 1'b0);

    // Latency: inputs change just after an edge, output holds until the next edge
    step("lat_pre", 2'b11, 4'b1101, 4'b1010, 1'b0);
    ALUOp = 2'b10;
    Inst  = 4'b0110;
    #2;
    check("lat_hold", {ALUSel, illegal}, 5'b1010_0);
    @(negedge clk);
    check("lat_hold_neg", {ALUSel, illegal}, 5'b1010_0);
    @(posedge clk);
    #1;
    check("lat_update", {ALUSel, illegal}, 5'b0100_0);

    // Async reset pulse between edges while ALUSel=SRA
    step("mid_pre", 2'b10, 4'b1101, 4'b1010, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_reset", {ALUSel, illegal}, 5'b0000_0);
    #1;
    rst = 1'b0;
    #1;
    check("mid_reset_hold", {ALUSel, illegal}, 5'b0000_0);
    @(posedge clk);
    #1;
    check("mid_reload", {ALUSel, illegal}, 5'b1010_0);

    // Pin the model itself against literals
    check("model_pin_rsub", model(2'b10, 4'b1000), 5'b0001_0);
    check("model_pin_iadd", model(2'b11, 4'b1000), 5'b0000_0);
    check("model_pin_iill", model(2'b11, 4'b1001), 5'b1001_1);
    check("model_pin_rill", model(2'b10, 4'b1010), 5'b1101_1);

    repeat (2) @(posedge clk);
    model_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
